alu_issue_stage: RTL

// - Producer side of the ALU operand/opcode interface: decodes an RV32I instruction into the
//   4-bit ALU Operation and selects SrcA/SrcB from PC, rs1, rs2 and immediate.
// - Registers the result as the ID/EX boundary using a 2-entry skid buffer with valid/ready
//   on both sides, so execute back-pressure never forms a combinational path into decode.

---
 rtl/alu_issue_stage_pkg.sv | 61 ++++++
 rtl/alu_issue_stage_if.sv | 33 +++
 rtl/alu_issue_stage_decoder.sv | 117 +++++++++++
 rtl/alu_issue_stage.sv | 85 ++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage: ALU op codes,
// RV32I opcode/funct fields and the decoded issue record.
package alu_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int OPCODE_LENGTH = 4;

    typedef enum logic [OPCODE_LENGTH-1:0] {
        OP_AND     = 4'b0000,
        OP_OR      = 4'b0001,
        OP_ADD     = 4'b0010,
        OP_XOR     = 4'b0011,
        OP_SLL     = 4'b0100,
        OP_SRL     = 4'b0101,
        OP_SUB     = 4'b0110,
        OP_SRA     = 4'b0111,
        OP_BEQ     = 4'b1000,
        OP_BNE     = 4'b1001,
        OP_BGE     = 4'b1010,
        OP_SLT     = 4'b1100,
        OP_JAL     = 4'b1101,
        OP_ILLEGAL = 4'b1111
    } alu_op_e;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 encodings used by OP / OP-IMM / BRANCH
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

    // funct7 encodings
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] src_a;
        logic [DATA_WIDTH-1:0] src_b;
        alu_op_e               op;
        logic                  illegal;
    } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute bus of the issue stage: upstream valid/ready with
// instruction operands, downstream valid/ready with ALU operands and op.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              instr;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     illegal;

    // Environment side: drives decode inputs, consumes execute outputs
    modport master (
        output flush, in_valid, instr, pc, rs1_data, rs2_data, imm, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, illegal
    );

    // Issue stage side
    modport slave (
        input  flush, in_valid, instr, pc, rs1_data, rs2_data, imm, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, illegal
    );
endinterface

// File: rtl/alu_issue_stage_decoder.sv
// Purely combinational RV32I -> ALU op decoder with operand selection.
// Anything the ALU op set cannot express is reported as illegal with
// zeroed operands.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [6:0]            funct7_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            opcode_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output issue_t                issue_o
);

    alu_op_e               op;
    logic                  bad;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  f7_zero;

    assign f7_zero = (funct7_i == F7_ZERO);

    // Opcode/funct decode, operand mux, then illegal override
    always_comb begin
        op    = OP_ILLEGAL;
        bad   = 1'b0;
        src_a = '0;
        src_b = '0;
        case (opcode_i)
            OPC_OP: begin
                src_a = rs1_i;
                src_b = rs2_i;
                case (funct3_i)
                    F3_ADD: begin
                        if (f7_zero)                  op = OP_ADD;
                        else if (funct7_i == F7_ALT)  op = OP_SUB;
                        else                          bad = 1'b1;
                    end
                    F3_SR: begin
                        if (f7_zero)                  op = OP_SRL;
                        else if (funct7_i == F7_ALT)  op = OP_SRA;
                        else                          bad = 1'b1;
                    end
                    F3_SLL: begin op = OP_SLL; bad = !f7_zero; end
                    F3_SLT: begin op = OP_SLT; bad = !f7_zero; end
                    F3_XOR: begin op = OP_XOR; bad = !f7_zero; end
                    F3_OR:  begin op = OP_OR;  bad = !f7_zero; end
                    F3_AND: begin op = OP_AND; bad = !f7_zero; end
                    default: bad = 1'b1;                  // SLTU
                endcase
            end
            OPC_OP_IMM: begin
                src_a = rs1_i;
                src_b = imm_i;
                case (funct3_i)
                    F3_ADD: op = OP_ADD;
                    F3_SLT: op = OP_SLT;
                    F3_XOR: op = OP_XOR;
                    F3_OR:  op = OP_OR;
                    F3_AND: op = OP_AND;
                    F3_SLL: begin op = OP_SLL; bad = !f7_zero; end
                    F3_SR: begin
                        // instr[30] picks arithmetic; the rest of funct7 must be clear
                        op  = funct7_i[5] ? OP_SRA : OP_SRL;
                        bad = funct7_i[6] || (funct7_i[4:0] != 5'd0);
                    end
                    default: bad = 1'b1;                  // SLTIU
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                op    = OP_ADD;
                src_a = rs1_i;
                src_b = imm_i;
            end
            OPC_BRANCH: begin
                src_a = rs1_i;
                src_b = rs2_i;
                case (funct3_i)
                    F3_BEQ:  op = OP_BEQ;
                    F3_BNE:  op = OP_BNE;
                    F3_BLT:  op = OP_SLT;
                    F3_BGE:  op = OP_BGE;
                    default: bad = 1'b1;                  // unsigned branches
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces pc+4 as the link value from pc on both inputs
                op    = OP_JAL;
                src_a = pc_i;
                src_b = pc_i;
            end
            OPC_LUI: begin
                op    = OP_ADD;
                src_b = imm_i;
            end
            OPC_AUIPC: begin
                op    = OP_ADD;
                src_a = pc_i;
                src_b = imm_i;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            op    = OP_ILLEGAL;
            src_a = '0;
            src_b = '0;
        end
    end

    assign issue_o.src_a   = src_a;
    assign issue_o.src_b   = src_b;
    assign issue_o.op      = op;
    assign issue_o.illegal = bad;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX boundary: decodes the incoming instruction and registers it in a
// two-entry skid buffer (OUT + SKID). in_ready depends only on SKID
// occupancy, so execute back-pressure never reaches decode combinationally.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_stage_if.slave  bus
);

    issue_t dec_issue;
    issue_t out_q, out_d;
    issue_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   drain;

    alu_op_decoder u_decoder (
        .funct7_i (bus.instr[31:25]),
        .funct3_i (bus.instr[14:12]),
        .opcode_i (bus.instr[6:0]),
        .pc_i     (bus.pc),
        .rs1_i    (bus.rs1_data),
        .rs2_i    (bus.rs2_data),
        .imm_i    (bus.imm),
        .issue_o  (dec_issue)
    );

    assign bus.in_ready = !skid_valid_q;
    assign accept       = bus.in_valid && !skid_valid_q;
    assign drain        = out_valid_q && bus.out_ready;

    // Next-state of OUT/SKID: flush wins, then drain refills from SKID or input
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d = dec_issue;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_d       = dec_issue;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec_issue;
                skid_valid_d = 1'b1;
            end
        end
    end

    // Buffer state registers; reset clears occupancy and output fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.SrcA      = out_q.src_a;
    assign bus.SrcB      = out_q.src_b;
    assign bus.Operation = out_q.op;
    assign bus.illegal   = out_q.illegal;

endmodule
